// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite palette bank.
// Fade support in the bank is enabled by defining PALETTE_FADE_EN.
package sprite_pkg;

    localparam int unsigned RGB_CW = 4;

    typedef struct packed {
        logic [RGB_CW-1:0] r;
        logic [RGB_CW-1:0] g;
        logic [RGB_CW-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        FADE_OUT
    } fade_state_e;

    // Brightness scale: level 2**cw is identity, 0 is black.
    function automatic logic [15:0] scale_chan(input logic [15:0] c,
                                               input logic [16:0] level,
                                               input int unsigned cw);
        logic [32:0] prod;
        prod = 33'(c) * 33'(level);
        return 16'(prod >> cw);
    endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Global brightness fade: steps level by one every FADE_DIV clocks toward the
// selected target, then returns to IDLE on the same edge the target is reached.
module palette_fade_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned FADE_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             dir_i,
    output logic [COLOR_W:0] level_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FADE_DIV - 1);
    localparam logic [COLOR_W:0] LVL_MAX = {1'b1, {COLOR_W{1'b0}}};

    fade_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COLOR_W:0] level_q, level_d;
    logic             busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= LVL_MAX;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        unique case (state_q)
            IDLE: begin
                // A start that is already at its target never leaves IDLE.
                if (start_i && dir_i && level_q != LVL_MAX) begin
                    state_d = FADE_IN;
                    cnt_d   = CNT_RELOAD;
                end else if (start_i && !dir_i && level_q != '0) begin
                    state_d = FADE_OUT;
                    cnt_d   = CNT_RELOAD;
                end
            end
            FADE_IN: begin
                if (cnt_q == '0) begin
                    level_d = level_q + 1'b1;
                    cnt_d   = CNT_RELOAD;
                    if (level_q == LVL_MAX - 1'b1) state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FADE_OUT: begin
                if (cnt_q == '0) begin
                    level_d = level_q - 1'b1;
                    cnt_d   = CNT_RELOAD;
                    if (level_q == {{COLOR_W{1'b0}}, 1'b1}) state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign level_o = level_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// Runtime-writable multi-palette colour lookup with a fixed 2-cycle read pipe.
// Define PALETTE_FADE_EN to enable the global brightness fade and S2 scaling.
module sprite_palette_bank
    import sprite_pkg::*;
#(
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned COLOR_W    = 4,
    parameter int unsigned NUM_PAL    = 8,
    parameter int unsigned TRANSP_IDX = 0,
    parameter int unsigned FADE_DIV   = 4,
    localparam int unsigned PAL_W     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 rd_valid,
    input  logic [PAL_W-1:0]     rd_pal,
    input  logic [IDX_W-1:0]     rd_index,
    output logic                 out_valid,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 transparent,
    input  logic                 wr_en,
    input  logic [PAL_W-1:0]     wr_pal,
    input  logic [IDX_W-1:0]     wr_index,
    input  logic [3*COLOR_W-1:0] wr_rgb,
    input  logic                 fade_start,
    input  logic                 fade_dir,
    output logic                 fade_busy,
    output logic [COLOR_W:0]     fade_level
);

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pix_t;

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam logic [PAL_W:0] PAL_LIM = (PAL_W + 1)'(NUM_PAL);
    localparam logic [COLOR_W:0] LVL_MAX = {1'b1, {COLOR_W{1'b0}}};
    localparam pix_t KEY = '{r: '1, g: '0, b: '1};

    pix_t             mem_q [NUM_PAL][ENTRIES];
    pix_t             rd_entry;
    logic             rd_ok, wr_ok;
    logic             s1_valid_q, s1_transp_q;
    pix_t             s1_rgb_q;
    pix_t             s2_rgb_d, out_rgb_q;
    logic             out_valid_q, out_transp_q;
    logic [COLOR_W:0] level_w;
    logic             busy_w;

    assign rd_ok = ({1'b0, rd_pal} < PAL_LIM);
    assign wr_ok = ({1'b0, wr_pal} < PAL_LIM);

    // Entry 0 of every palette resets to the magenta colour key.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned p = 0; p < NUM_PAL; p++) begin
                for (int unsigned e = 0; e < ENTRIES; e++) begin
                    mem_q[p][e] <= (e == 0) ? KEY : '0;
                end
            end
        end else if (wr_en && wr_ok) begin
            mem_q[wr_pal][wr_index] <= wr_rgb;
        end
    end

    assign rd_entry = rd_ok ? mem_q[rd_pal][rd_index] : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_transp_q  <= 1'b0;
            s1_rgb_q     <= '0;
            out_valid_q  <= 1'b0;
            out_transp_q <= 1'b0;
            out_rgb_q    <= '0;
        end else begin
            s1_valid_q  <= rd_valid;
            out_valid_q <= s1_valid_q;
            if (rd_valid) begin
                s1_rgb_q    <= rd_entry;
                s1_transp_q <= (rd_index == IDX_W'(TRANSP_IDX));
            end
            if (s1_valid_q) begin
                out_rgb_q    <= s2_rgb_d;
                out_transp_q <= s1_transp_q;
            end
        end
    end

`ifdef PALETTE_FADE_EN
    palette_fade_ctrl #(
        .COLOR_W (COLOR_W),
        .FADE_DIV(FADE_DIV)
    ) u_fade (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .start_i(fade_start),
        .dir_i  (fade_dir),
        .level_o(level_w),
        .busy_o (busy_w)
    );

    always_comb begin
        s2_rgb_d   = '0;
        s2_rgb_d.r = COLOR_W'(scale_chan(16'(s1_rgb_q.r), 17'(level_w), COLOR_W));
        s2_rgb_d.g = COLOR_W'(scale_chan(16'(s1_rgb_q.g), 17'(level_w), COLOR_W));
        s2_rgb_d.b = COLOR_W'(scale_chan(16'(s1_rgb_q.b), 17'(level_w), COLOR_W));
    end
`else
    localparam int unsigned unused_fade_div = FADE_DIV;
    logic unused_fade_in;
    assign unused_fade_in = fade_start ^ fade_dir;
    assign level_w  = LVL_MAX;
    assign busy_w   = 1'b0;
    assign s2_rgb_d = s1_rgb_q;
`endif

    assign out_valid   = out_valid_q;
    assign red         = out_rgb_q.r;
    assign green       = out_rgb_q.g;
    assign blue        = out_rgb_q.b;
    assign transparent = out_transp_q;
    assign fade_busy   = busy_w;
    assign fade_level  = level_w;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank: directed steps plus random
// read/write traffic against an array-based palette model.
module tb_sprite_palette_bank;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        rd_valid;
    logic [2:0]  rd_pal;
    logic [3:0]  rd_index;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        wr_en;
    logic [2:0]  wr_pal;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        fade_start, fade_dir;
    logic        fade_busy;
    logic [4:0]  fade_level;

    int checks = 0;
    int failures = 0;

    logic [11:0] mm [8][16];
    int          ml;
    bit          q0_v, q1_v, q0_t, q1_t, hold_t;
    logic [11:0] q0_rgb, q1_rgb, hold_rgb;

    always #5 Clk = ~Clk;

    sprite_palette_bank #(
        .IDX_W(4), .COLOR_W(4), .NUM_PAL(8), .TRANSP_IDX(0), .FADE_DIV(4)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .rd_valid(rd_valid), .rd_pal(rd_pal), .rd_index(rd_index),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue),
        .transparent(transparent),
        .wr_en(wr_en), .wr_pal(wr_pal), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .fade_start(fade_start), .fade_dir(fade_dir),
        .fade_busy(fade_busy), .fade_level(fade_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] fade_rgb(input logic [11:0] c, input int lvl);
        int r, g, b;
        r = (int'(c[11:8]) * lvl) / 16;
        g = (int'(c[7:4]) * lvl) / 16;
        b = (int'(c[3:0]) * lvl) / 16;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 8; p++)
            for (int e = 0; e < 16; e++)
                mm[p][e] = (e == 0) ? 12'hF0F : 12'h000;
        ml = 16;
        q0_v = 0; q1_v = 0; q0_t = 0; q1_t = 0; hold_t = 0;
        q0_rgb = '0; q1_rgb = '0; hold_rgb = '0;
    endtask

    // One clock: check the request issued two cycles ago, then drive a new one.
    task automatic cyc(input bit rv, input int rp, input int ri,
                       input bit we, input int wp, input int wi, input logic [11:0] wd);
        @(negedge Clk);
        if (q1_v) begin
            hold_rgb = q1_rgb;
            hold_t   = q1_t;
        end
        chk("out_valid", out_valid, q1_v);
        chk("rgb", {red, green, blue}, hold_rgb);
        chk("transparent", transparent, hold_t);
        q1_v = q0_v; q1_rgb = q0_rgb; q1_t = q0_t;
        rd_valid = rv; rd_pal = rp[2:0]; rd_index = ri[3:0];
        wr_en = we; wr_pal = wp[2:0]; wr_index = wi[3:0]; wr_rgb = wd;
        q0_v = rv;
        q0_rgb = fade_rgb(mm[rp][ri], ml);
        q0_t = (ri == 0);
        if (we) mm[wp][wi] = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 12'h000);
    endtask

    task automatic run_fade(input bit dir, output int cnt);
        cnt = 0;
        fade_start = 1'b1; fade_dir = dir;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            fade_start = 1'b0;
            if (fade_busy) cnt++;
            else break;
        end
    endtask

    initial begin
        int cnt, rd_at;
        bit seen8;
        logic exp_busy;

        Reset_n = 1'b0;
        rd_valid = 0; rd_pal = 0; rd_index = 0;
        wr_en = 0; wr_pal = 0; wr_index = 0; wr_rgb = 0;
        fade_start = 0; fade_dir = 0;
        model_reset();

        @(negedge Clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rgb", {red, green, blue}, 12'h000);
        chk("rst_transparent", transparent, 1'b0);
        chk("rst_fade_level", fade_level, 5'd16);
        chk("rst_fade_busy", fade_busy, 1'b0);
        Reset_n = 1'b1;

        // Reset contents: colour key at index 0, black elsewhere
        cyc(1, 3, 0, 0, 0, 0, 12'h000);
        cyc(1, 3, 5, 0, 0, 0, 12'h000);
        idle(2);

        // Same-cycle read returns old data, next-cycle read sees the write
        cyc(1, 2, 7, 1, 2, 7, 12'hBA0);
        cyc(1, 2, 7, 0, 0, 0, 12'h000);
        idle(2);

        // Back-to-back reads, full throughput
        cyc(1, 2, 3, 1, 2, 3, 12'h123);
        for (int i = 0; i < 16; i++) cyc(1, 2, i, 0, 0, 0, 12'h000);
        idle(2);

        // Random reads and writes
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15),
                12'($urandom));
        idle(2);

`ifdef PALETTE_FADE_EN
        cyc(0, 0, 0, 1, 1, 1, 12'hFFF);
        idle(2);

        // Fade out with an ignored restart mid-fade and a read at level 8
        cnt = 0; rd_at = -10; seen8 = 0;
        fade_start = 1'b1; fade_dir = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            fade_start = 1'b0; rd_valid = 1'b0;
            if (fade_busy) cnt++;
            if (k == 10) begin
                fade_start = 1'b1; fade_dir = 1'b1;
            end
            if (k == rd_at + 2) begin
                chk("lvl8_out_valid", out_valid, 1'b1);
                chk("lvl8_rgb", {red, green, blue}, fade_rgb(12'hFFF, 8));
            end
            if (!seen8 && fade_level == 5'd8) begin
                seen8 = 1; rd_at = k;
                rd_valid = 1'b1; rd_pal = 3'd1; rd_index = 4'd1;
            end
            if (!fade_busy) break;
        end
        fade_dir = 1'b0;
        chk("fade_out_seen8", seen8, 1'b1);
        chk("fade_out_cycles", cnt, 64);
        chk("fade_out_level", fade_level, 5'd0);
        chk("fade_out_busy", fade_busy, 1'b0);
        hold_rgb = fade_rgb(12'hFFF, 8); hold_t = 0;

        ml = 0;
        cyc(1, 1, 1, 0, 0, 0, 12'h000);
        cyc(1, 3, 0, 0, 0, 0, 12'h000);
        idle(2);

        run_fade(1'b1, cnt);
        chk("fade_in_cycles", cnt, 64);
        chk("fade_in_level", fade_level, 5'd16);
        ml = 16;
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif

        // Fade-in request already at full brightness stays idle
        @(negedge Clk);
        fade_start = 1'b1; fade_dir = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            fade_start = 1'b0;
            chk("fade_in_at_max_busy", fade_busy, 1'b0);
        end
        chk("fade_in_at_max_level", fade_level, 5'd16);

        // Asynchronous reset mid-fade with reads in flight
        fade_start = 1'b1; fade_dir = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            fade_start = 1'b0;
            rd_valid = (k >= 7); rd_pal = 3'd3; rd_index = 4'd0;
        end
        chk("pre_reset_busy", fade_busy, exp_busy);
        @(posedge Clk);
        #2;
        chk("pre_reset_out_valid", out_valid, 1'b1);
        Reset_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_fade_level", fade_level, 5'd16);
        chk("async_fade_busy", fade_busy, 1'b0);
        chk("async_rgb", {red, green, blue}, 12'h000);
        @(negedge Clk);
        rd_valid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        cyc(1, 2, 7, 0, 0, 0, 12'h000);
        cyc(1, 3, 0, 0, 0, 0, 12'h000);
        idle(3);
        chk("post_reset_busy", fade_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
